i2s_stereo_rx: RTL
==================

# i2s_stereo_rx

Stereo I2S receiver for a pair of MEMS microphones sharing one data line (one mic SEL low = left, one SEL high = right). Generates the bit clock and word-select clock from `audio_clk`, deserialises both 24-bit slots and delivers 16-bit signed samples with one-cycle valid strobes at 48 kHz. Sits directly upstream of the anti-alias FIR / DC-blocker / 48k→24k decimation chain and replaces the per-mic receivers, so one PMOD pin pair serves two mics.

## Interface
- `BCLK_DIV`, 32: `audio_clk` cycles per BCLK period; even, ≥4. Frame rate = f_audio_clk / (64·BCLK_DIV), which is 48 kHz at 98.304 MHz.
- `WARMUP_FRAMES`, 16'd4096: frames discarded after enable before valids are issued. 0 means no warm-up.

Ports:
- `audio_clk` in 1: single clock for the whole block.
- `rst_in` in 1: reset, asynchronous, active-low.
- `enable` in 1: run request.
- `mic_data` in 1: shared serial data pin, asynchronous to `audio_clk`.
- `bclk_out` out 1: I2S bit clock to the mics.
- `lrcl_out` out 1: word select; 0 = left slot, 1 = right slot.
- `left_out` out 16 signed: latest left sample.
- `right_out` out 16 signed: latest right sample.
- `left_valid` out 1: one-cycle strobe; `left_out` is new.
- `right_valid` out 1: one-cycle strobe; `right_out` is new.
- `running` out 1: high in RUN state.

## Operation
- `mic_data` passes through a 2-flop synchronizer before use.
- Counters:
  - `phase` runs 0..BCLK_DIV-1.
  - `bit_cnt` runs 0..63 and advances when `phase`=BCLK_DIV-1.
  - `bit_cnt` wraps 63→0 with no gap.
- Clock outputs (registered):
  - `bclk_out` = 0 for phase < BCLK_DIV/2, else 1.
  - `lrcl_out` = bit_cnt[5].
  - Both therefore change only together with a BCLK falling edge.
- Slot index k = bit_cnt[4:0].
  - k=0 is the I2S one-bit delay and is ignored.
  - k=1..24 carry data, MSB first. At phase=BCLK_DIV-1 the synchronized bit shifts into a 24-bit register.
  - k=25..31 are ignored; the mic tristates here.
- Sample output:
  - After the k=24 shift of the left slot, `left_out` ← word[23:8] (truncation, no rounding).
  - The right slot behaves the same way for `right_out`.
- States:
  - IDLE: counters held at 0; `bclk_out` = 0 and `lrcl_out` = 0; no valids. If `enable`=1, go to WARMUP (or straight to RUN when WARMUP_FRAMES=0). Counters start at phase 0, bit 0 on the next cycle.
  - WARMUP: clocks run and data is shifted, but outputs and valids are suppressed. A frame counter increments at each frame end (bit_cnt=63, phase=BCLK_DIV-1). When it reaches WARMUP_FRAMES, go to RUN from frame start.
  - RUN: outputs and valids are issued; `running`=1.
- Disable handling:
  - `enable` is sampled only at frame end in WARMUP and RUN.
  - If 0 at that point, go to IDLE. The in-progress frame completes, including its right_valid.
  - A low pulse on `enable` that is gone by frame end has no effect.
- Re-enable from IDLE restarts the full warm-up.
- `left_out` and `right_out` hold their last values in IDLE.

## Timing
- Reset values:
  - `bclk_out`, `lrcl_out`, `left_valid`, `right_valid`, `running` = 0.
  - `left_out`, `right_out` = 16'sd0.
  - State IDLE; all counters 0.
- Assertion of `rst_in` mid-frame forces these values immediately; no partial sample is emitted.
- Data sampling point is phase BCLK_DIV-1 of the high half. This is BCLK_DIV/2−1 cycles after the rising edge and before the next falling edge, where the mic changes data.
- Pin-to-register latency is 2 cycles (synchronizer) plus 1 cycle (shift).
- Valid timing:
  - `left_valid` is high exactly one cycle: the cycle after the edge that shifts left k=24.
  - `left_out` changes on that same edge, so it is valid coincident with the strobe.
  - `right_valid` follows the same rule, exactly 32·BCLK_DIV cycles after `left_valid`.
- In RUN, valids repeat every 64·BCLK_DIV cycles (2048 at default). There is no backpressure.
- `running` rises on the first cycle of the first RUN frame and falls on entry to IDLE.

## Test plan
Bench parameters: BCLK_DIV=4, WARMUP_FRAMES=2. The bench mic model drives a bit after each BCLK falling edge, I2S format.

- Clock shape: assert `enable` -> `bclk_out` period 4 cycles at 50% duty; `lrcl_out` period 256 cycles; every `lrcl_out` edge coincides with a `bclk_out` falling edge.
- Data path: left slot 24'hABCDEF, right slot 24'h123456 -> `left_out`=16'hABCD with `left_valid` one cycle; `right_out`=16'h1234 exactly 128 cycles later.
- Sign and extremes: left 24'h800000, right 24'h7FFFFF -> 16'h8000 and 16'h7FFF. 24'hFFFFFF -> 16'hFFFF.
- Warm-up: enable with distinct data each frame -> no valids in frames 0–1; first `left_valid` carries frame 2's left word; `running` rises at frame 2 start.
- Disable mid-frame: drop `enable` at bit 10 of a RUN frame -> that frame's `left_valid` and `right_valid` both occur; `bclk_out` and `lrcl_out` are 0 from the next frame on; outputs hold. A 3-cycle low pulse on `enable` at bit 10 -> no interruption.
- Reset mid-frame: assert `rst_in` at bit 20 of a left slot -> all outputs 0 immediately; no valid. After release with `enable`=1, full warm-up repeats before the next valid.

Source files
------------

// File: rtl/i2s_stereo_rx.sv
// Stereo I2S receiver: two MEMS mics on one data pin, BCLK/LRCL generation,
// 24-bit slot capture, 16-bit truncated samples with one-cycle valid strobes.
module i2s_stereo_rx #(
    parameter int unsigned BCLK_DIV      = 32,
    parameter logic [15:0] WARMUP_FRAMES = 16'd4096
) (
    input  logic               audio_clk,
    input  logic               rst_in,
    input  logic               enable,
    input  logic               mic_data,
    output logic               bclk_out,
    output logic               lrcl_out,
    output logic signed [15:0] left_out,
    output logic signed [15:0] right_out,
    output logic               left_valid,
    output logic               right_valid,
    output logic               running
);

    localparam int unsigned    PW      = $clog2(BCLK_DIV);
    localparam logic [PW-1:0] PH_LAST = PW'(BCLK_DIV - 1);
    localparam logic [PW-1:0] PH_HALF = PW'(BCLK_DIV / 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WARMUP,
        S_RUN
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [5:0]    bit_q, bit_d;
    logic [15:0]   frm_q, frm_d;
    logic [1:0]    sync_q;
    logic [23:0]   shreg_q, shreg_d;
    logic [15:0]   left_q, left_d;
    logic [15:0]   right_q, right_d;
    logic          lv_q, lv_d;
    logic          rv_q, rv_d;
    logic          bclk_q, bclk_d;
    logic          lrcl_q, lrcl_d;

    logic          counting;
    logic          bit_end;
    logic          frame_end;
    logic [4:0]    slot_k;
    logic          shift_en;
    logic          last_bit;
    logic [23:0]   word_d;

    assign counting  = (state_q != S_IDLE);
    assign bit_end   = counting && (phase_q == PH_LAST);
    assign frame_end = bit_end && (bit_q == 6'd63);
    assign slot_k    = bit_q[4:0];
    assign shift_en  = bit_end && (slot_k >= 5'd1) && (slot_k <= 5'd24);
    assign last_bit  = bit_end && (slot_k == 5'd24);
    assign word_d    = {shreg_q[22:0], sync_q[1]};

    // State register
    always_ff @(posedge audio_clk or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: enable only matters at frame end once running
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = (WARMUP_FRAMES == 16'd0) ? S_RUN : S_WARMUP;
                end
            end
            S_WARMUP: begin
                if (frame_end) begin
                    if (!enable) begin
                        state_d = S_IDLE;
                    end else if (frm_q + 16'd1 == WARMUP_FRAMES) begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (frame_end && !enable) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        phase_d = '0;
        bit_d   = '0;
        frm_d   = '0;
        if (counting && state_d != S_IDLE) begin
            phase_d = bit_end ? '0 : phase_q + 1'b1;
            bit_d   = bit_end ? bit_q + 6'd1 : bit_q;
            frm_d   = (state_q == S_WARMUP && frame_end) ? frm_q + 16'd1 : frm_q;
        end
    end

    // Clock pins are derived from next-state counters so they line up with them
    always_comb begin
        bclk_d  = (state_d != S_IDLE) && (phase_d >= PH_HALF);
        lrcl_d  = (state_d != S_IDLE) && bit_d[5];
        shreg_d = shift_en ? word_d : shreg_q;
        left_d  = left_q;
        right_d = right_q;
        lv_d    = 1'b0;
        rv_d    = 1'b0;
        if (state_q == S_RUN && last_bit) begin
            if (bit_q[5]) begin
                right_d = word_d[23:8];
                rv_d    = 1'b1;
            end else begin
                left_d = word_d[23:8];
                lv_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge audio_clk or negedge rst_in) begin
        if (!rst_in) begin
            phase_q <= '0;
            bit_q   <= '0;
            frm_q   <= '0;
            sync_q  <= '0;
            shreg_q <= '0;
            left_q  <= '0;
            right_q <= '0;
            lv_q    <= 1'b0;
            rv_q    <= 1'b0;
            bclk_q  <= 1'b0;
            lrcl_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            bit_q   <= bit_d;
            frm_q   <= frm_d;
            sync_q  <= {sync_q[0], mic_data};
            shreg_q <= shreg_d;
            left_q  <= left_d;
            right_q <= right_d;
            lv_q    <= lv_d;
            rv_q    <= rv_d;
            bclk_q  <= bclk_d;
            lrcl_q  <= lrcl_d;
        end
    end

    always_comb begin
        running     = (state_q == S_RUN);
        bclk_out    = bclk_q;
        lrcl_out    = lrcl_q;
        left_out    = left_q;
        right_out   = right_q;
        left_valid  = lv_q;
        right_valid = rv_q;
    end

endmodule
